ptb_axi4_lite_regbank: RTL and testbench



---
 rtl/ptb_axi4_lite_regbank_pkg.sv | 47 ++++
 rtl/ptb_axi4_lite_regbank_decode.sv | 44 ++++
 rtl/ptb_axi4_lite_regbank.sv | 246 ++++++++++++++++++++++++
 tb/tb_ptb_axi4_lite_regbank.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptb_axi4_lite_regbank_pkg.sv
// Shared types and constants for the AXI4-Lite register bank: response codes,
// write/read FSM encodings, address-region tags and word-offset helpers.
package ptb_axi4_lite_regbank_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STRB_W     = DATA_W / 8;
    localparam int WORD_SHIFT = 2;                    // byte address -> word offset
    localparam int OFFSET_W   = ADDR_W - WORD_SHIFT;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WIDLE    = 2'd0,
        WHAVE_AW = 2'd1,
        WHAVE_W  = 2'd2,
        WRESP    = 2'd3
    } wstate_e;

    typedef enum logic {
        RIDLE = 1'b0,
        RDATA = 1'b1
    } rstate_e;

    typedef enum logic [1:0] {
        REGION_IN   = 2'd0,
        REGION_CTRL = 2'd1,
        REGION_STAT = 2'd2
    } region_e;

    // Index width able to address n entries, never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Expand byte strobes into a per-bit write mask.
    function automatic logic [DATA_W-1:0] strb_mask(input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int b = 0; b < STRB_W; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/ptb_axi4_lite_regbank_decode.sv
// Combinational address decoder: maps a byte address onto the register window
// as {region, index within region, decode error}.
module ptb_axi_lite_decode
    import ptb_axi4_lite_regbank_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h7C80_0000,
    parameter int                N_IN      = 3,
    parameter int                N_OUT     = 2,
    parameter int                IDX_W     = 2
) (
    input  logic [ADDR_W-1:0] addr,
    output region_e           region,
    output logic [IDX_W-1:0]  index,
    output logic              err
);

    localparam logic [OFFSET_W-1:0] CTRL_OFF = OFFSET_W'(N_IN);
    localparam logic [OFFSET_W-1:0] STAT_OFF = OFFSET_W'(N_IN + 1);
    localparam logic [OFFSET_W-1:0] END_OFF  = OFFSET_W'(N_IN + 1 + N_OUT);

    logic [ADDR_W-1:0]   rel_addr;
    logic [OFFSET_W-1:0] offset;

    assign rel_addr = addr - BASE_ADDR;
    assign offset   = OFFSET_W'(rel_addr >> WORD_SHIFT);

    // Classify the word offset; anything outside the window or misaligned is an error.
    always_comb begin
        region = REGION_IN;
        index  = '0;
        err    = 1'b0;
        if ((addr < BASE_ADDR) || (addr[WORD_SHIFT-1:0] != '0) || (offset >= END_OFF)) begin
            err = 1'b1;
        end else if (offset < CTRL_OFF) begin
            index = IDX_W'(offset);
        end else if (offset == CTRL_OFF) begin
            region = REGION_CTRL;
        end else begin
            region = REGION_STAT;
            index  = IDX_W'(offset - STAT_OFF);
        end
    end

endmodule

// File: rtl/ptb_axi4_lite_regbank.sv
// AXI4-Lite register bank: writable core-input registers, a write-only CTRL
// word that produces a start pulse, and read-only core status fields.
module ptb_axi4_lite_regbank
    import ptb_axi4_lite_regbank_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h7C80_0000,
    parameter int          N_IN       = 3,
    parameter int          IN_W       = 5,
    parameter int          N_OUT      = 2,
    parameter int          OUT_W      = 4,
    parameter int          OUT_SIGNED = 1
) (
    input  logic                                      S_AXI_ACLK,
    input  logic                                      S_AXI_ARESET,
    input  logic [31:0]                               S_AXI_AWADDR,
    input  logic                                      S_AXI_AWVALID,
    output logic                                      S_AXI_AWREADY,
    input  logic [31:0]                               S_AXI_WDATA,
    input  logic [3:0]                                S_AXI_WSTRB,
    input  logic                                      S_AXI_WVALID,
    output logic                                      S_AXI_WREADY,
    output logic [1:0]                                S_AXI_BRESP,
    output logic                                      S_AXI_BVALID,
    input  logic                                      S_AXI_BREADY,
    input  logic [31:0]                               S_AXI_ARADDR,
    input  logic                                      S_AXI_ARVALID,
    output logic                                      S_AXI_ARREADY,
    output logic [31:0]                               S_AXI_RDATA,
    output logic [1:0]                                S_AXI_RRESP,
    output logic                                      S_AXI_RVALID,
    input  logic                                      S_AXI_RREADY,
    output logic [N_IN*IN_W-1:0]                      o_core_data,
    output logic                                      o_core_wr_en,
    output logic [((N_IN > 1) ? $clog2(N_IN) : 1)-1:0] o_core_wr_idx,
    output logic                                      o_core_start,
    input  logic [N_OUT*OUT_W-1:0]                    i_core_status
);

    localparam int WR_IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int IDX_W    = idx_bits((N_IN > N_OUT) ? N_IN : N_OUT);
    localparam int IDX_N    = 1 << IDX_W;

    // ---------------- write path signals ----------------
    wstate_e             wstate_reg, wstate_next;
    logic                awready_reg, wready_reg, bvalid_reg;
    logic [1:0]          bresp_reg;
    logic [31:0]         awaddr_reg, wdata_reg;
    logic [3:0]          wstrb_reg;
    logic                aw_hs, w_hs, w_commit;
    logic [31:0]         w_addr, w_data, w_mask;
    logic [3:0]          w_strb;
    region_e             w_region;
    logic [IDX_W-1:0]    w_index;
    logic                w_err, w_ok, w_to_in;
    logic                core_wr_en_reg, core_start_reg;
    logic [WR_IDX_W-1:0] core_wr_idx_reg;
    logic                unused_ok;

    // ---------------- read path signals ----------------
    rstate_e             rstate_reg, rstate_next;
    logic                arready_reg, rvalid_reg;
    logic [31:0]         rdata_reg, rd_word;
    logic [1:0]          rresp_reg, rd_resp;
    region_e             r_region;
    logic [IDX_W-1:0]    r_index;
    logic                r_err, ar_hs;
    logic [31:0]         in_word   [IDX_N];
    logic [31:0]         stat_word [IDX_N];

    assign aw_hs = S_AXI_AWVALID && awready_reg;
    assign w_hs  = S_AXI_WVALID && wready_reg;
    assign ar_hs = S_AXI_ARVALID && arready_reg;

    // The committing beat may come from a held channel or from the live bus.
    assign w_addr = (wstate_reg == WHAVE_AW) ? awaddr_reg : S_AXI_AWADDR;
    assign w_data = (wstate_reg == WHAVE_W)  ? wdata_reg  : S_AXI_WDATA;
    assign w_strb = (wstate_reg == WHAVE_W)  ? wstrb_reg  : S_AXI_WSTRB;
    assign w_mask = strb_mask(w_strb);

    assign w_commit = (wstate_next == WRESP) && (wstate_reg != WRESP);
    assign w_ok     = !w_err && (w_region != REGION_STAT);
    assign w_to_in  = w_commit && !w_err && (w_region == REGION_IN);

    // Only the low IN_W data bits feed the registers; the rest is ignored by design.
    assign unused_ok = ^{w_data, w_mask};

    ptb_axi_lite_decode #(
        .BASE_ADDR (BASE_ADDR),
        .N_IN      (N_IN),
        .N_OUT     (N_OUT),
        .IDX_W     (IDX_W)
    ) u_wr_decode (
        .addr   (w_addr),
        .region (w_region),
        .index  (w_index),
        .err    (w_err)
    );

    ptb_axi_lite_decode #(
        .BASE_ADDR (BASE_ADDR),
        .N_IN      (N_IN),
        .N_OUT     (N_OUT),
        .IDX_W     (IDX_W)
    ) u_rd_decode (
        .addr   (S_AXI_ARADDR),
        .region (r_region),
        .index  (r_index),
        .err    (r_err)
    );

    // Input registers, one per generate slot; unused slots read back as zero.
    genvar gi;
    for (gi = 0; gi < IDX_N; gi++) begin : g_in
        if (gi < N_IN) begin : g_reg
            logic [IN_W-1:0] val_reg;
            // Byte-wise merge of the committed write into this register.
            always_ff @(posedge S_AXI_ACLK) begin
                if (S_AXI_ARESET) begin
                    val_reg <= '0;
                end else if (w_to_in && (w_index == IDX_W'(gi))) begin
                    val_reg <= (val_reg & ~w_mask[IN_W-1:0]) | (w_data[IN_W-1:0] & w_mask[IN_W-1:0]);
                end
            end
            assign o_core_data[gi*IN_W +: IN_W] = val_reg;
            assign in_word[gi] = 32'(val_reg);
        end else begin : g_pad
            assign in_word[gi] = '0;
        end
    end

    // Status fields extended to a full bus word, signed or unsigned.
    for (gi = 0; gi < IDX_N; gi++) begin : g_stat
        if (gi < N_OUT) begin : g_field
            logic [OUT_W-1:0] field;
            assign field = i_core_status[gi*OUT_W +: OUT_W];
            assign stat_word[gi] = (OUT_SIGNED != 0) ? 32'(signed'(field)) : 32'(field);
        end else begin : g_pad
            assign stat_word[gi] = '0;
        end
    end

    // Write FSM next state: AW and W collected in either order, then respond.
    always_comb begin
        wstate_next = wstate_reg;
        unique case (wstate_reg)
            WIDLE: begin
                if (aw_hs && w_hs) wstate_next = WRESP;
                else if (aw_hs)    wstate_next = WHAVE_AW;
                else if (w_hs)     wstate_next = WHAVE_W;
            end
            WHAVE_AW: if (w_hs)         wstate_next = WRESP;
            WHAVE_W:  if (aw_hs)        wstate_next = WRESP;
            WRESP:    if (S_AXI_BREADY) wstate_next = WIDLE;
            default:                    wstate_next = WIDLE;
        endcase
    end

    // Write state, channel holding registers, response and core-side pulses.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wstate_reg      <= WIDLE;
            awready_reg     <= 1'b0;
            wready_reg      <= 1'b0;
            bvalid_reg      <= 1'b0;
            bresp_reg       <= RESP_OKAY;
            awaddr_reg      <= '0;
            wdata_reg       <= '0;
            wstrb_reg       <= '0;
            core_wr_en_reg  <= 1'b0;
            core_wr_idx_reg <= '0;
            core_start_reg  <= 1'b0;
        end else begin
            wstate_reg  <= wstate_next;
            awready_reg <= (wstate_next == WIDLE) || (wstate_next == WHAVE_W);
            wready_reg  <= (wstate_next == WIDLE) || (wstate_next == WHAVE_AW);
            bvalid_reg  <= (wstate_next == WRESP);
            if (aw_hs) awaddr_reg <= S_AXI_AWADDR;
            if (w_hs) begin
                wdata_reg <= S_AXI_WDATA;
                wstrb_reg <= S_AXI_WSTRB;
            end
            if (w_commit) bresp_reg <= w_ok ? RESP_OKAY : RESP_SLVERR;
            core_wr_en_reg <= w_to_in;
            if (w_to_in) core_wr_idx_reg <= WR_IDX_W'(w_index);
            core_start_reg <= w_commit && !w_err && (w_region == REGION_CTRL)
                              && w_strb[0] && w_data[0];
        end
    end

    // Read data selection at the AR handshake.
    always_comb begin
        rd_word = '0;
        rd_resp = RESP_OKAY;
        if (r_err) begin
            rd_resp = RESP_SLVERR;
        end else begin
            unique case (r_region)
                REGION_IN:   rd_word = in_word[r_index];
                REGION_STAT: rd_word = stat_word[r_index];
                default:     rd_word = '0;
            endcase
        end
    end

    // Read FSM next state: one outstanding read at a time.
    always_comb begin
        rstate_next = rstate_reg;
        unique case (rstate_reg)
            RIDLE:   if (ar_hs)        rstate_next = RDATA;
            RDATA:   if (S_AXI_RREADY) rstate_next = RIDLE;
            default:                   rstate_next = RIDLE;
        endcase
    end

    // Read state and registered response, held until RREADY.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rstate_reg  <= RIDLE;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
        end else begin
            rstate_reg  <= rstate_next;
            arready_reg <= (rstate_next == RIDLE);
            rvalid_reg  <= (rstate_next == RDATA);
            if (ar_hs) begin
                rdata_reg <= rd_word;
                rresp_reg <= rd_resp;
            end
        end
    end

    assign S_AXI_AWREADY = awready_reg;
    assign S_AXI_WREADY  = wready_reg;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_BRESP   = bresp_reg;
    assign S_AXI_ARREADY = arready_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RDATA   = rdata_reg;
    assign S_AXI_RRESP   = rresp_reg;
    assign o_core_wr_en  = core_wr_en_reg;
    assign o_core_wr_idx = core_wr_idx_reg;
    assign o_core_start  = core_start_reg;

endmodule

// File: tb/tb_ptb_axi4_lite_regbank.sv
// Scoreboard bench for the AXI4-Lite register bank: stimulus pushes expected
// responses into queues, monitors pop and compare on each DUT handshake/pulse.
module tb_ptb_axi4_lite_regbank;

    localparam logic [31:0] BASE   = 32'h7C80_0000;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef struct { logic [1:0] idx; logic [4:0] val; } wr_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; } r_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic [3:0]  wstrb = '0;
    logic        bready = 1'b1, rready = 1'b1;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [14:0] core_data;
    logic        wr_en, start;
    logic [1:0]  wr_idx;
    logic [7:0]  status = 8'h2A;

    int checks = 0;
    int failures = 0;
    int start_seen = 0;
    int start_exp = 0;

    logic [1:0] b_q[$];
    r_t         r_q[$];
    wr_t        wr_q[$];

    always #5 clk = ~clk;

    ptb_axi4_lite_regbank dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .o_core_data   (core_data),
        .o_core_wr_en  (wr_en),
        .o_core_wr_idx (wr_idx),
        .o_core_start  (start),
        .i_core_status (status)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    task automatic expect_b(input logic [1:0] resp);
        b_q.push_back(resp);
    endtask

    task automatic expect_r(input logic [31:0] d, input logic [1:0] resp);
        r_t e;
        e.data = d;
        e.resp = resp;
        r_q.push_back(e);
    endtask

    task automatic expect_wr(input logic [1:0] idx, input logic [4:0] v);
        wr_t e;
        e.idx = idx;
        e.val = v;
        wr_q.push_back(e);
    endtask

    task automatic drive_aw(input logic [31:0] a, input int dly);
        bit done;
        done = 1'b0;
        repeat (dly) tick();
        awaddr = a;
        awvalid = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (awready) done = 1'b1;
        end
        tick();
        awvalid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL aw_timeout actual=no_awready required=awready addr=%h", a);
        end
    endtask

    task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        bit done;
        done = 1'b0;
        repeat (dly) tick();
        wdata = d;
        wstrb = s;
        wvalid = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (wready) done = 1'b1;
        end
        tick();
        wvalid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL w_timeout actual=no_wready required=wready data=%h", d);
        end
    endtask

    task automatic drive_ar(input logic [31:0] a);
        bit done;
        done = 1'b0;
        araddr = a;
        arvalid = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (arready) done = 1'b1;
        end
        tick();
        arvalid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL ar_timeout actual=no_arready required=arready addr=%h", a);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd);
        fork
            drive_aw(a, awd);
            drive_w(d, s, wd);
        join
    endtask

    task automatic read_chk(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        expect_r(d, resp);
        drive_ar(a);
        settle();
    endtask

    // Write-response monitor.
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (bvalid && bready) begin
                if (b_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_unexpected actual=bresp %b required=no response", bresp);
                end else begin
                    e = b_q.pop_front();
                    check("bresp", {30'd0, bresp}, {30'd0, e});
                end
            end
        end
    end

    // Read-response monitor.
    initial begin
        r_t e;
        forever begin
            @(negedge clk);
            if (rvalid && rready) begin
                if (r_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL r_unexpected actual=rdata %h required=no response", rdata);
                end else begin
                    e = r_q.pop_front();
                    check("rdata", rdata, e.data);
                    check("rresp", {30'd0, rresp}, {30'd0, e.resp});
                end
            end
        end
    end

    // Core write-pulse monitor and start-pulse counter.
    initial begin
        wr_t e;
        logic [14:0] sh;
        forever begin
            @(negedge clk);
            if (start) start_seen++;
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected actual=idx %0d required=no pulse", wr_idx);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_idx", {30'd0, wr_idx}, {30'd0, e.idx});
                    sh = core_data >> (e.idx * 5);
                    check("wr_data", {27'd0, sh[4:0]}, {27'd0, e.val});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        repeat (3) tick();
        check("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
        check("rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_core", {13'd0, core_data, wr_en, wr_idx, start}, 32'd0);
        rst = 1'b0;
        repeat (2) tick();
        check("ready_after_rst", {29'd0, awready, wready, arready}, 32'd7);

        // AW first, W three cycles later: BVALID one cycle after W.
        expect_b(OKAY);
        expect_wr(2'd1, 5'h1F);
        do_write(BASE + 32'h4, 32'h1F, 4'hF, 0, 3);
        check("b_latency", {31'd0, bvalid}, 32'd1);
        check("wr_pulse", {29'd0, wr_en, wr_idx}, {29'd0, 1'b1, 2'd1});
        settle();
        check("core_data_r1", {17'd0, core_data}, 32'h03E0);

        // Partial strobes: only byte 0 reaches a 5-bit register.
        expect_b(OKAY); expect_wr(2'd0, 5'h0B);
        do_write(BASE, 32'hAB, 4'h1, 0, 0); settle();
        expect_b(OKAY); expect_wr(2'd2, 5'h00);
        do_write(BASE + 32'h8, 32'h15, 4'h2, 0, 0); settle();
        expect_b(OKAY); expect_wr(2'd2, 5'h16);
        do_write(BASE + 32'h8, 32'hFFFF_FF16, 4'hF, 1, 0); settle();

        // CTRL start pulse, AW+W in the same cycle.
        expect_b(OKAY); start_exp++;
        do_write(BASE + 32'hC, 32'h1, 4'hF, 0, 0);
        check("start_pulse", {31'd0, start}, 32'd1);
        check("ctrl_b_latency", {31'd0, bvalid}, 32'd1);
        tick();
        check("start_one_cycle", {31'd0, start}, 32'd0);
        settle();
        check("core_data_after_ctrl", {17'd0, core_data}, 32'h5BEB);
        // CTRL without byte-0 strobe, and with bit 0 clear: no pulse.
        expect_b(OKAY);
        do_write(BASE + 32'hC, 32'h1, 4'hE, 0, 0); settle();
        expect_b(OKAY);
        do_write(BASE + 32'hC, 32'h2, 4'hF, 0, 0); settle();

        // W before AW.
        expect_b(OKAY); expect_wr(2'd0, 5'h07);
        do_write(BASE, 32'h7, 4'h1, 2, 0); settle();

        // Reads: status sign-extension and register readback.
        expect_r(32'hFFFF_FFFA, OKAY);
        drive_ar(BASE + 32'h10);
        check("r_latency", {31'd0, rvalid}, 32'd1);
        settle();
        read_chk(BASE + 32'h14, 32'h0000_0002, OKAY);
        read_chk(BASE + 32'h04, 32'h0000_001F, OKAY);
        read_chk(BASE + 32'h0C, 32'h0000_0000, OKAY);
        read_chk(BASE + 32'h00, 32'h0000_0007, OKAY);
        read_chk(BASE + 32'h08, 32'h0000_0016, OKAY);

        // Decode errors and read-only status writes.
        expect_b(SLVERR);
        do_write(BASE + 32'h10, 32'hF, 4'hF, 0, 0); settle();
        expect_b(SLVERR);
        do_write(BASE + 32'h18, 32'h1, 4'hF, 0, 0); settle();
        expect_b(SLVERR);
        do_write(BASE + 32'hD, 32'h1, 4'hF, 0, 0); settle();
        read_chk(BASE + 32'h2, 32'h0, SLVERR);
        read_chk(BASE - 32'h4, 32'h0, SLVERR);
        read_chk(BASE + 32'h18, 32'h0, SLVERR);
        check("core_data_after_err", {17'd0, core_data}, 32'h5BE7);

        // Simultaneous read and write of the same register returns the old value.
        expect_r(32'h1F, OKAY);
        expect_b(OKAY); expect_wr(2'd1, 5'h0A);
        fork
            do_write(BASE + 32'h4, 32'h0A, 4'hF, 0, 0);
            drive_ar(BASE + 32'h4);
        join
        settle();
        read_chk(BASE + 32'h4, 32'h0A, OKAY);
        check("core_data_collide", {17'd0, core_data}, 32'h5947);

        // Write-response backpressure.
        bready = 1'b0;
        expect_b(OKAY); expect_wr(2'd0, 5'h03);
        do_write(BASE, 32'h3, 4'hF, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bhold_valid_resp", {29'd0, bvalid, bresp}, 32'd4);
            check("bhold_no_accept", {30'd0, awready, wready}, 32'd0);
        end
        tick();
        bready = 1'b1;
        settle();

        // Read-data backpressure; status changes must not disturb held data.
        rready = 1'b0;
        expect_r(32'hFFFF_FFFA, OKAY);
        drive_ar(BASE + 32'h10);
        status = 8'h5C;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rhold_valid_resp", {29'd0, rvalid, rresp}, 32'd4);
            check("rhold_data", rdata, 32'hFFFF_FFFA);
            check("rhold_no_accept", {31'd0, arready}, 32'd0);
        end
        tick();
        rready = 1'b1;
        settle();
        read_chk(BASE + 32'h10, 32'hFFFF_FFFC, OKAY);
        read_chk(BASE + 32'h14, 32'h0000_0005, OKAY);

        // Reset while holding AW: everything clears and a lone W gets no response.
        drive_aw(BASE + 32'h4, 0);
        check("whave_aw_ready", {30'd0, awready, wready}, 32'd1);
        rst = 1'b1;
        tick();
        check("rst_mid_ready_valid", {27'd0, awready, wready, arready, bvalid, rvalid}, 32'd0);
        check("rst_mid_core", {13'd0, core_data, wr_en, wr_idx, start}, 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        rst = 1'b0;
        tick();
        drive_w(32'h1F, 4'hF, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bvalid) seen++;
        end
        check("no_bvalid_after_rst", seen, 32'd0);

        check("b_queue_empty", b_q.size(), 32'd0);
        check("r_queue_empty", r_q.size(), 32'd0);
        check("wr_queue_empty", wr_q.size(), 32'd0);
        check("start_count", start_seen, start_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
